// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the IFU fetch port and the LSU data port.
// One outstanding req/gnt/rvalid transaction at a time; LSU has priority, bounded by IFU starvation.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    // IFU fetch port
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_valid_o,
    output logic                stallreq_if_o,
    // LSU data port
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_sel_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_valid_o,
    output logic                stallreq_ls_o,
    // Memory bus
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned      CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic [1:0] {OwnNone, OwnIf, OwnLs} owner_e;

    state_e           r_state;
    owner_e           r_owner;
    logic             r_kill;
    logic [CNT_W-1:0] r_starve_cnt;

    logic w_if_elig;
    logic w_ls_elig;
    logic w_if_win;
    logic w_ls_win;
    logic w_done;
    logic w_kill;

    // A requester is masked in its own completion cycle so the same request is not re-accepted.
    assign w_if_elig = if_req_i && !if_valid_o && !flush_i;
    assign w_ls_elig = ls_req_i && !ls_valid_o;
    assign w_if_win  = w_if_elig && (!w_ls_elig || (r_starve_cnt == CNT_MAX));
    assign w_ls_win  = w_ls_elig && !w_if_win;

    assign w_done = mem_rvalid_i && (((r_state == StReq) && mem_gnt_i) || (r_state == StWait));
    // A flush arriving on the response cycle still kills the fetch.
    assign w_kill = r_kill || flush_i;

    assign stallreq_if_o = if_req_i && !if_valid_o;
    assign stallreq_ls_o = ls_req_i && !ls_valid_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_owner      <= OwnNone;
            r_kill       <= 1'b0;
            r_starve_cnt <= '0;
            if_data_o    <= '0;
            if_valid_o   <= 1'b0;
            ls_rdata_o   <= '0;
            ls_valid_o   <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_sel_o    <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            if_valid_o <= 1'b0;
            ls_valid_o <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_if_win) begin
                        r_owner      <= OwnIf;
                        r_state      <= StReq;
                        r_kill       <= 1'b0;
                        r_starve_cnt <= '0;
                        mem_req_o    <= 1'b1;
                        mem_we_o     <= 1'b0;
                        mem_sel_o    <= '1;
                        mem_addr_o   <= if_addr_i;
                        mem_wdata_o  <= '0;
                    end else if (w_ls_win) begin
                        r_owner     <= OwnLs;
                        r_state     <= StReq;
                        r_kill      <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= ls_we_i;
                        mem_sel_o   <= ls_sel_i;
                        mem_addr_o  <= ls_addr_i;
                        mem_wdata_o <= ls_wdata_i;
                        if (w_if_elig && (r_starve_cnt != CNT_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                    end
                end
                StReq: begin
                    if (flush_i && (r_owner == OwnIf)) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_rvalid_i) begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (flush_i && (r_owner == OwnIf)) begin
                        r_kill <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_done) begin
                if (r_owner == OwnLs) begin
                    ls_valid_o <= 1'b1;
                    ls_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                end else if ((r_owner == OwnIf) && !w_kill) begin
                    if_valid_o <= 1'b1;
                    if_data_o  <= mem_rdata_i;
                end
                r_owner <= OwnNone;
                r_kill  <= 1'b0;
                r_state <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized traffic against a
// transaction-level model of the arbitration, kill and completion rules.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_data_o;
    logic          if_valid_o;
    logic          stallreq_if_o;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [3:0]    ls_sel_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic [DW-1:0] ls_rdata_o;
    logic          ls_valid_o;
    logic          stallreq_ls_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_sel_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SM)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_data_o    (if_data_o),
        .if_valid_o   (if_valid_o),
        .stallreq_if_o(stallreq_if_o),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_sel_i     (ls_sel_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_rdata_o   (ls_rdata_o),
        .ls_valid_o   (ls_valid_o),
        .stallreq_ls_o(stallreq_ls_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_sel_o    (mem_sel_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i      = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        ls_req_i     = 1'b0;
        ls_we_i      = 1'b0;
        ls_sel_i     = '0;
        ls_addr_i    = '0;
        ls_wdata_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    function automatic logic [31:0] new_if_addr();
        return {16'h8000, 14'($urandom), 2'b00};
    endfunction

    function automatic logic [31:0] new_ls_addr();
        return {16'h4000, 16'($urandom)};
    endfunction

    // Reference model state: one transaction in flight, seen from the bus and requester sides.
    bit          busy = 0, granted = 0, own_if = 0, kill = 0;
    bit          e_if_v = 0, e_ls_v = 0, m_req_exp = 0, mode_starve = 0, prev_req = 0;
    int          streak = 0, rwait = 0;
    logic [31:0] e_if_d, e_ls_d, x_addr, x_wdata;
    logic        x_we;
    logic [3:0]  x_sel;
    bit          own_log[$];

    task automatic eng_step();
        bit if_el, ls_el, n_if_v, n_ls_v, g, rv;
        check("e_mem_req", mem_req_o, m_req_exp);
        if (m_req_exp) begin
            check("e_mem_addr", mem_addr_o, x_addr);
            check("e_mem_we", mem_we_o, x_we);
            check("e_mem_sel", mem_sel_o, x_sel);
            if (x_we) check("e_mem_wdata", mem_wdata_o, x_wdata);
        end
        if (mem_req_o && !prev_req) own_log.push_back(mem_addr_o[31]);
        prev_req = mem_req_o;
        check("e_if_valid", if_valid_o, e_if_v);
        check("e_if_data", if_data_o, e_if_d);
        check("e_ls_valid", ls_valid_o, e_ls_v);
        check("e_ls_rdata", ls_rdata_o, e_ls_d);
        check("e_stall_if", stallreq_if_o, if_req_i && !e_if_v);
        check("e_stall_ls", stallreq_ls_o, ls_req_i && !e_ls_v);

        // Requesters hold a request until its completion pulse.
        if (!if_req_i || e_if_v) begin
            if_req_i  = mode_starve ? 1'b1 : ($urandom_range(0, 3) != 0);
            if_addr_i = new_if_addr();
        end
        flush_i = mode_starve ? e_ls_v : ($urandom_range(0, 7) == 0);
        if (flush_i && if_req_i) if_addr_i = new_if_addr();
        if (!ls_req_i || e_ls_v) begin
            ls_req_i   = mode_starve ? 1'b1 : ($urandom_range(0, 2) != 0);
            ls_we_i    = $urandom_range(0, 1);
            ls_sel_i   = 4'($urandom);
            ls_addr_i  = new_ls_addr();
            ls_wdata_i = $urandom;
        end

        g = 0;
        rv = 0;
        mem_rdata_i = $urandom;
        if (busy) begin
            if (!granted) begin
                g = ($urandom_range(0, 2) == 0);
                if (g) begin
                    rv    = $urandom_range(0, 1);
                    rwait = $urandom_range(0, 2);
                end
            end else if (rwait == 0) begin
                rv = 1;
            end else begin
                rwait--;
            end
        end
        mem_gnt_i    = g;
        mem_rvalid_i = rv;

        n_if_v = 0;
        n_ls_v = 0;
        if (busy) begin
            if (flush_i && own_if) kill = 1;
            if (g) granted = 1;
            if (rv) begin
                busy = 0;
                if (!own_if) begin
                    n_ls_v = 1;
                    e_ls_d = x_we ? 32'h0 : mem_rdata_i;
                end else if (!kill) begin
                    n_if_v = 1;
                    e_if_d = mem_rdata_i;
                end
            end
            m_req_exp = busy && !granted;
        end else begin
            if_el = if_req_i && !e_if_v && !flush_i;
            ls_el = ls_req_i && !e_ls_v;
            if (if_el && (!ls_el || streak == SM)) begin
                own_if = 1;
                streak = 0;
                x_addr = if_addr_i;
                x_we   = 1'b0;
                x_sel  = 4'hF;
                busy   = 1;
            end else if (ls_el) begin
                own_if = 0;
                if (if_el && streak < SM) streak++;
                x_addr  = ls_addr_i;
                x_we    = ls_we_i;
                x_sel   = ls_sel_i;
                x_wdata = ls_wdata_i;
                busy    = 1;
            end
            granted   = 0;
            kill      = 0;
            m_req_exp = busy;
        end
        e_if_v = n_if_v;
        e_ls_v = n_ls_v;
    endtask

    initial begin
        logic [4:0] pat;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_mem_req", mem_req_o, 0);
        check("rst_if_valid", if_valid_o, 0);
        check("rst_ls_valid", ls_valid_o, 0);
        check("rst_mem_sel", mem_sel_o, 0);
        rst = 1'b0;

        // Single fetch, minimum latency
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0000;
        step();
        check("t1_req", mem_req_o, 1);
        check("t1_addr", mem_addr_o, 32'h8000_0000);
        check("t1_sel", mem_sel_o, 4'hF);
        check("t1_we", mem_we_o, 0);
        check("t1_stall1", stallreq_if_o, 1);
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0413;
        step();
        check("t1_valid", if_valid_o, 1);
        check("t1_data", if_data_o, 32'h0000_0413);
        check("t1_stall2", stallreq_if_o, 0);
        check("t1_req_drop", mem_req_o, 0);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hFFFF_FFFF;
        step();
        check("t1_no_reissue", mem_req_o, 0);
        check("t1_pulse", if_valid_o, 0);
        if_req_i = 1'b0;

        // LSU write, grant delayed three cycles
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_sel_i   = 4'h3;
        ls_addr_i  = 32'h8000_1000;
        ls_wdata_i = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("t2_req", mem_req_o, 1);
            check("t2_addr", mem_addr_o, 32'h8000_1000);
            check("t2_we", mem_we_o, 1);
            check("t2_sel", mem_sel_o, 4'h3);
            check("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            check("t2_stall", stallreq_ls_o, 1);
            if (c == 4) mem_gnt_i = 1'b1;
        end
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA5A5_A5A5;
        check("t2_wait_req", mem_req_o, 0);
        check("t2_early", ls_valid_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        check("t2_valid", ls_valid_o, 1);
        check("t2_rdata", ls_rdata_o, 0);
        step();
        check("t2_pulse", ls_valid_o, 0);
        check("t2_no_reissue", mem_req_o, 0);
        ls_req_i = 1'b0;

        // Flush in WAIT kills the fetch; redirected fetch follows
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0010;
        step();
        check("t3_req", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        flush_i   = 1'b1;
        if_addr_i = 32'h8000_0100;
        step();
        flush_i = 1'b0;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_0BAD;
        step();
        mem_rvalid_i = 1'b0;
        check("t3_killed", if_valid_o, 0);
        check("t3_idle", mem_req_o, 0);
        step();
        check("t3_refetch", mem_req_o, 1);
        check("t3_ref_addr", mem_addr_o, 32'h8000_0100);
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0093;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check("t3_valid", if_valid_o, 1);
        check("t3_data", if_data_o, 32'h0000_0093);
        step();
        if_req_i = 1'b0;
        check("t3_pulse", if_valid_o, 0);

        // Reset while waiting for the response
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0200;
        step();
        check("t4_req", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rst_req", mem_req_o, 0);
        check("t4_rst_addr", mem_addr_o, 0);
        check("t4_rst_data", if_data_o, 0);
        check("t4_rst_valid", if_valid_o, 0);
        step();
        check("t4_fresh_req", mem_req_o, 1);
        check("t4_fresh_addr", mem_addr_o, 32'h8000_0200);
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0513;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check("t4_valid", if_valid_o, 1);
        check("t4_data", if_data_o, 32'h0000_0513);
        step();
        if_req_i = 1'b0;

        // LSU read with concurrent fetch: LSU first, fetch served once right after
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0300;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_sel_i  = 4'hF;
        ls_addr_i = 32'h4000_0040;
        step();
        check("t5_ls_addr", mem_addr_o, 32'h4000_0040);
        check("t5_ls_we", mem_we_o, 0);
        check("t5_stall_if", stallreq_if_o, 1);
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check("t5_ls_valid", ls_valid_o, 1);
        check("t5_ls_rdata", ls_rdata_o, 32'h1234_5678);
        ls_req_i = 1'b0;
        step();
        check("t5_if_req", mem_req_o, 1);
        check("t5_if_addr", mem_addr_o, 32'h8000_0300);
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00A0_0093;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check("t5_if_valid", if_valid_o, 1);
        check("t5_if_data", if_data_o, 32'h00A0_0093);
        step();
        check("t5_no_dup", mem_req_o, 0);
        check("t5_pulse", if_valid_o, 0);
        if_req_i = 1'b0;

        // Continuous contention: LSU x4 then IFU, with flush masking the LSU completion cycles
        e_if_d      = 32'h00A0_0093;
        e_ls_d      = 32'h1234_5678;
        mode_starve = 1;
        own_log.delete();
        for (int i = 0; i < 120; i++) begin
            step();
            eng_step();
        end
        pat = 5'b10000;
        check("starve_cnt", own_log.size() >= 5, 1);
        for (int k = 0; k < 5 && k < own_log.size(); k++) begin
            check("starve_order", own_log[k], pat[k]);
        end

        mode_starve = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            eng_step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
